// File: rtl/cell_ctrl_pkg.sv
// Shared types for the two-bank cell cache scheduler: bank states,
// writer/reader FSM encodings and the default frame size.
package cell_ctrl_pkg;

  localparam int CELL_NUM_DEF = 1200;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_st_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_BUSY = 2'd2
  } wr_st_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DRAIN = 2'd2
  } rd_st_e;

  // A bank holds valid frame data while it is FULL or being drained.
  function automatic logic bank_has_data(input bank_st_e s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/cell_bank_state.sv
// Per-bank state holder. Each event is only honoured from the state that
// precedes it in the EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY ring.
module cell_bank_state
  import cell_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     fill,
  input  logic     full,
  input  logic     drain,
  input  logic     free,
  output bank_st_e state
);

  bank_st_e state_next;

  // Advance around the bank ring on the matching event.
  always_comb begin
    state_next = state;
    case (state)
      BANK_EMPTY:    if (fill)  state_next = BANK_FILLING;
      BANK_FILLING:  if (full)  state_next = BANK_FULL;
      BANK_FULL:     if (drain) state_next = BANK_DRAINING;
      BANK_DRAINING: if (free)  state_next = BANK_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BANK_EMPTY;
    else        state <= state_next;
  end

endmodule

// File: rtl/cell_bank_ctrl.sv
// Ping-pong scheduler for the two-bank cell cache. The writer FSM hands the
// frame-fetch writer an empty bank; the reader FSM pulses the cell-fetch start
// for the next full bank and frees it after CELL_NUM forward handshakes.
// Banks are used strictly in order 0,1,0,1...
// Optional macro CELL_BANK_CTRL_PERF_EN adds frame_cnt_o / stall_cnt_o.
module cell_bank_ctrl
  import cell_ctrl_pkg::*;
#(
  parameter int CELL_NUM = CELL_NUM_DEF
`ifdef CELL_BANK_CTRL_PERF_EN
  , parameter int FRAME_CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl_en_i,
  output logic       wr_req_o,
  output logic       wr_bank_o,
  input  logic       wr_ack_i,
  input  logic       wr_done_i,
  output logic       fetch_start_o,
  output logic       rd_bank_o,
  input  logic       fwd_cell_valid_i,
  input  logic       fwd_cell_ready_i,
  output logic [1:0] bank_full_o,
  output logic       busy_o,
  output logic       err_o
`ifdef CELL_BANK_CTRL_PERF_EN
  , output logic [FRAME_CNT_W-1:0] frame_cnt_o
  , output logic [FRAME_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int CNT_W = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_NUM - 1);

  wr_st_e           w_state, w_next;
  rd_st_e           r_state, r_next;
  logic             wr_bank, wr_bank_next;
  logic             rd_bank, rd_bank_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       fill_ev, full_ev, drain_ev, free_ev;
  bank_st_e         bank_st [2];
  logic             hs;
  logic             drain_done;
  logic             err_q, err_now;

  assign hs = fwd_cell_valid_i & fwd_cell_ready_i;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    cell_bank_state u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .fill  (fill_ev[i]),
      .full  (full_ev[i]),
      .drain (drain_ev[i]),
      .free  (free_ev[i]),
      .state (bank_st[i])
    );
  end

  // Writer FSM: claim the next bank when empty, hold the request until ack,
  // then wait for the frame-done pulse.
  always_comb begin
    w_next       = w_state;
    wr_bank_next = wr_bank;
    fill_ev      = '0;
    full_ev      = '0;
    case (w_state)
      W_IDLE: begin
        if (ctrl_en_i && (bank_st[wr_bank] == BANK_EMPTY)) begin
          w_next           = W_REQ;
          fill_ev[wr_bank] = 1'b1;
        end
      end
      W_REQ: begin
        if (wr_ack_i) w_next = W_BUSY;
      end
      W_BUSY: begin
        if (wr_done_i) begin
          w_next           = W_IDLE;
          full_ev[wr_bank] = 1'b1;
          wr_bank_next     = ~wr_bank;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Reader FSM: start a drain on the next full bank, count handshakes and
  // free the bank on the last one.
  always_comb begin
    r_next       = r_state;
    rd_bank_next = rd_bank;
    cnt_next     = cnt;
    drain_ev     = '0;
    free_ev      = '0;
    drain_done   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (bank_st[rd_bank] == BANK_FULL) begin
          r_next            = R_START;
          drain_ev[rd_bank] = 1'b1;
        end
      end
      R_START: begin
        cnt_next = '0;
        r_next   = R_DRAIN;
      end
      R_DRAIN: begin
        if (hs) begin
          if (cnt == CNT_LAST) begin
            cnt_next         = '0;
            free_ev[rd_bank] = 1'b1;
            rd_bank_next     = ~rd_bank;
            drain_done       = 1'b1;
            r_next           = R_IDLE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Protocol violations are flagged but otherwise have no effect.
  assign err_now = (wr_done_i && (w_state != W_BUSY)) ||
                   (wr_ack_i  && (w_state != W_REQ))  ||
                   (hs        && (r_state != R_DRAIN));

  // FSM state, bank pointers, drain counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      wr_bank <= wr_bank_next;
      rd_bank <= rd_bank_next;
      cnt     <= cnt_next;
      err_q   <= err_q | err_now;
    end
  end

  assign wr_req_o      = (w_state == W_REQ);
  assign fetch_start_o = (r_state == R_START);
  assign wr_bank_o     = wr_bank;
  assign rd_bank_o     = rd_bank;
  assign bank_full_o   = {bank_has_data(bank_st[1]), bank_has_data(bank_st[0])};
  assign busy_o        = (bank_st[0] != BANK_EMPTY) || (bank_st[1] != BANK_EMPTY) ||
                         (w_state != W_IDLE) || (r_state != R_IDLE);
  assign err_o         = err_q;

`ifdef CELL_BANK_CTRL_PERF_EN
  logic stall;
  assign stall = (w_state == W_IDLE) && ctrl_en_i && (bank_st[wr_bank] != BANK_EMPTY);

  // Completed-drain counter wraps; writer-stall counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (drain_done)                 frame_cnt_o <= frame_cnt_o + 1'b1;
      if (stall && !(&stall_cnt_o))   stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_bank_ctrl.sv
// Scoreboard bench for cell_bank_ctrl with CELL_NUM=4. Directed stimulus
// pushes the expected request / fetch-start events (bank and cycle) into
// queues; a monitor pops and compares whenever the DUT presents one.
module tb_cell_bank_ctrl;

  localparam int CELL_NUM = 4;

  logic       clk = 1'b0;
  logic       rst_n, ctrl_en, wr_ack, wr_done, valid, ready;
  logic       wr_req, wr_bank, fetch_start, rd_bank, busy, err;
  logic [1:0] bank_full;
`ifdef CELL_BANK_CTRL_PERF_EN
  logic [15:0] frame_cnt, stall_cnt;
`endif

  typedef struct {
    int bank;
    int cyc;
  } ev_t;

  ev_t  q_wr[$];
  ev_t  q_rd[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   rd_abort = 1'b0;
  logic wr_req_q = 1'b0;

  cell_bank_ctrl #(.CELL_NUM(CELL_NUM)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ctrl_en_i        (ctrl_en),
    .wr_req_o         (wr_req),
    .wr_bank_o        (wr_bank),
    .wr_ack_i         (wr_ack),
    .wr_done_i        (wr_done),
    .fetch_start_o    (fetch_start),
    .rd_bank_o        (rd_bank),
    .fwd_cell_valid_i (valid),
    .fwd_cell_ready_i (ready),
    .bank_full_o      (bank_full),
    .busy_o           (busy),
    .err_o            (err)
`ifdef CELL_BANK_CTRL_PERF_EN
    , .frame_cnt_o    (frame_cnt)
    , .stall_cnt_o    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return {24'd0, wr_req, wr_bank, fetch_start, rd_bank, bank_full, busy, err};
  endfunction

  task automatic push_wr(input int bank, input int c);
    ev_t e;
    e.bank = bank; e.cyc = c;
    q_wr.push_back(e);
  endtask

  task automatic push_rd(input int bank, input int c);
    ev_t e;
    e.bank = bank; e.cyc = c;
    q_rd.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    int i;
    i = 0;
    while (wr_req !== 1'b1 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (wr_req !== 1'b1) check("wr_req_timeout", {31'd0, wr_req}, 32'd1);
  endtask

  task automatic req_ack(input int ack_dly, input bit drop_en);
    wait_req();
    if (drop_en) ctrl_en = 1'b0;
    repeat (ack_dly) @(negedge clk);
    if (ack_dly > 0) check("wr_req_held", {31'd0, wr_req}, 32'd1);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
  endtask

  task automatic pulse_done();
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  // Monitor: compare every request rise and fetch-start pulse to the queues.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (wr_req === 1'b1 && wr_req_q !== 1'b1) begin
          if (q_wr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL wr_req_unexpected: request on bank %0d at cycle %0d, expected none", wr_bank, cyc);
          end else begin
            e = q_wr.pop_front();
            check("wr_req_bank", {31'd0, wr_bank}, e.bank);
            check("wr_req_cycle", cyc, e.cyc);
          end
        end
        if (fetch_start === 1'b1) begin
          if (q_rd.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL fetch_start_unexpected: start on bank %0d at cycle %0d, expected none", rd_bank, cyc);
          end else begin
            e = q_rd.pop_front();
            check("fetch_start_bank", {31'd0, rd_bank}, e.bank);
            check("fetch_start_cycle", cyc, e.cyc);
          end
        end
      end
      wr_req_q = wr_req;
    end
  end

  // Cell-fetch model: after each start pulse, present CELL_NUM cells.
  initial begin
    int n;
    valid = 1'b0;
    forever begin
      @(negedge clk);
      if (fetch_start === 1'b1 && !rd_abort) begin
        @(negedge clk);
        valid = 1'b1;
        n = 0;
        while (n < CELL_NUM && !rd_abort) begin
          @(posedge clk);
          if (ready) n++;
          @(negedge clk);
        end
        valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CELL_BANK_CTRL_PERF_EN
    int s0;
`endif
    rst_n = 1'b0; ctrl_en = 1'b0; wr_ack = 1'b0; wr_done = 1'b0; ready = 1'b1;
    wait_cyc(3);
    check("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);
    check("idle_after_reset", outs(), 32'd0);

    // Normal ping-pong: bank 0 written, drained while bank 1 is written.
    push_wr(0, cyc + 1);
    ctrl_en = 1'b1;
    req_ack(0, 1'b0);
    wait_cyc(9);
    push_rd(0, cyc + 2);
    push_wr(1, cyc + 2);
    pulse_done();
    req_ack(0, 1'b0);
    check("t1_bank_full_draining", {30'd0, bank_full}, 32'b01);
    check("t1_wr_bank", {31'd0, wr_bank}, 32'd1);
    wait_cyc(9);
    check("t1_bank0_freed", {30'd0, bank_full}, 32'b00);
    check("t1_rd_bank_toggled", {31'd0, rd_bank}, 32'd1);

    // Consumer stalled: both banks fill, writer stalls.
    push_rd(1, cyc + 2);
    push_wr(0, cyc + 2);
    ready = 1'b0;
    pulse_done();
    req_ack(0, 1'b0);
    wait_cyc(9);
    pulse_done();
    wait_cyc(3);
    check("t2_no_request", {31'd0, wr_req}, 32'd0);
    check("t2_both_full", {30'd0, bank_full}, 32'b11);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_wr_bank", {31'd0, wr_bank}, 32'd1);
`ifdef CELL_BANK_CTRL_PERF_EN
    s0 = int'(stall_cnt);
    wait_cyc(4);
    check("t2_stall_cnt", {16'd0, stall_cnt}, s0 + 4);
`endif

    // Release consumer; then align bank-1 done with the last bank-0 handshake.
    push_wr(1, cyc + 5);
    push_rd(0, cyc + 5);
    ready = 1'b1;
    wait_cyc(4);
    ready = 1'b0;
    req_ack(0, 1'b0);
    ready = 1'b1;
    wait_cyc(3);
    ready = 1'b0;
    wait_cyc(3);
    push_rd(1, cyc + 2);
    push_wr(0, cyc + 2);
    ready = 1'b1;
    pulse_done();
    check("t3_simul_bank_full", {30'd0, bank_full}, 32'b10);
    check("t3_rd_bank", {31'd0, rd_bank}, 32'd1);
    check("t3_wr_bank", {31'd0, wr_bank}, 32'd0);
    check("t3_no_err", {31'd0, err}, 32'd0);

    // Enable dropped during W_REQ with a late ack.
    req_ack(5, 1'b1);
    wait_cyc(9);
    push_rd(0, cyc + 2);
    pulse_done();
    wait_cyc(12);
    check("t4_not_busy", {31'd0, busy}, 32'd0);
    check("t4_banks_empty", {30'd0, bank_full}, 32'b00);
    check("t4_no_request", {31'd0, wr_req}, 32'd0);
    check("t4_no_err", {31'd0, err}, 32'd0);
`ifdef CELL_BANK_CTRL_PERF_EN
    check("t4_frame_cnt", {16'd0, frame_cnt}, 32'd5);
`endif

    // Spurious frame-done while idle.
    pulse_done();
    check("t5_err_set", {31'd0, err}, 32'd1);
    check("t5_banks_unchanged", {30'd0, bank_full}, 32'b00);
    check("t5_not_busy", {31'd0, busy}, 32'd0);
    wait_cyc(5);
    check("t5_err_sticky", {31'd0, err}, 32'd1);

    // Reset during a drain after two handshakes.
    push_wr(1, cyc + 1);
    ctrl_en = 1'b1;
    req_ack(0, 1'b0);
    wait_cyc(9);
    push_rd(1, cyc + 2);
    push_wr(0, cyc + 2);
    pulse_done();
    wait_cyc(4);
    rd_abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset_outputs", outs(), 32'd0);
    wait_cyc(3);
    check("t6_reset_hold_outputs", outs(), 32'd0);
    rd_abort = 1'b0;
    push_wr(0, cyc + 1);
    rst_n = 1'b1;
    wait_cyc(3);
    check("t6_req_after_reset", {31'd0, wr_req}, 32'd1);
    check("t6_wr_bank_after_reset", {31'd0, wr_bank}, 32'd0);

    check("wr_queue_drained", q_wr.size(), 32'd0);
    check("rd_queue_drained", q_rd.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_bank_ctrl.md
Name: cell_bank_ctrl

Overview:
Ping-pong scheduler for a two-bank cell cache sitting between the AXI4 frame-fetch writer and the cell-fetch reader. It grants the writer an empty bank and tells the reader, with a start pulse, which full bank to stream. It frees a bank once it has counted CELL_NUM forward cell handshakes. The writer can fill one bank while the other drains.

Parameters:
CELL_NUM, 1200, cells per frame (handshakes per bank drain)
FRAME_CNT_W, 16, width of perf counters (optional feature only)
CNT_W, $clog2(CELL_NUM), drain counter width; derived, do not override

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ctrl_en_i  in  1  enable continuous frame capture
wr_req_o  out  1  request writer to load a frame into wr_bank_o
wr_bank_o  out  1  target bank for writer
wr_ack_i  in  1  writer accepted request
wr_done_i  in  1  one-cycle pulse: frame fully written
fetch_start_o  out  1  one-cycle pulse to cell-fetch start input
rd_bank_o  out  1  bank currently being read
fwd_cell_valid_i  in  1  monitored cell-fetch output valid
fwd_cell_ready_i  in  1  monitored consumer ready
bank_full_o  out  2  per-bank FULL-or-DRAINING flag
busy_o  out  1  any bank not EMPTY or any FSM not idle
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): all outputs 0; both banks EMPTY; wr_bank=rd_bank=0; both FSMs idle; drain counter 0.
- Bank state per bank: EMPTY, FILLING, FULL, DRAINING.
- Writer FSM W_IDLE/W_REQ/W_BUSY:
  - W_IDLE: if ctrl_en_i and bank[wr_bank]==EMPTY, go to W_REQ; that bank becomes FILLING.
  - W_REQ: wr_req_o=1 (registered, Moore) and is held until wr_ack_i, even if ctrl_en_i drops; on ack go to W_BUSY.
  - W_BUSY: on wr_done_i, bank becomes FULL, wr_bank toggles, go to W_IDLE.
- Reader FSM R_IDLE/R_START/R_DRAIN:
  - R_IDLE: if bank[rd_bank]==FULL, go to R_START; the bank becomes DRAINING.
  - R_START: fetch_start_o=1 for exactly one cycle; counter cleared; go to R_DRAIN.
  - R_DRAIN: counter increments on each fwd_cell_valid_i & fwd_cell_ready_i. On the handshake with counter==CELL_NUM-1, the bank becomes EMPTY, rd_bank toggles, counter returns to 0, go to R_IDLE.
- Latency:
  - wr_done_i sampled at edge t: fetch_start_o high in cycle t+2 if the reader is idle.
  - Final drain handshake at t: the writer may raise wr_req_o for that bank in cycle t+2.
- Banks are filled and drained strictly in order 0,1,0,1…; no skipping.
- Simultaneous events: wr_done_i on one bank and drain completion on the other in the same cycle both take effect. Both banks FULL is legal; the writer stalls in W_IDLE.
- ctrl_en_i low: no new requests. An in-flight write completes; all FULL banks still drain; busy_o falls once everything is EMPTY and idle.
- Errors: the following set err_o (sticky until reset) and are otherwise ignored:
  - wr_done_i outside W_BUSY
  - wr_ack_i outside W_REQ
  - fwd handshake outside R_DRAIN
- Reset mid-frame: all state cleared immediately; no pulse is emitted on the edge where rst_n deasserts.

Optional Feature:
CELL_BANK_CTRL_PERF_EN: adds outputs frame_cnt_o [FRAME_CNT_W] and stall_cnt_o [FRAME_CNT_W].
- frame_cnt_o increments per completed drain and wraps.
- stall_cnt_o counts cycles with the writer in W_IDLE, ctrl_en_i=1 and bank[wr_bank]!=EMPTY; it saturates at all-ones.
- Both reset to 0.
- Without the macro, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package cell_ctrl_pkg: bank-state enum, writer/reader FSM encodings, default CELL_NUM.
- One sub-module, cell_bank_state, instanced per bank: takes fill/full/drain/free events and holds the 2-bit state. The top contains both FSMs and the counter.

Test Plan:
- CELL_NUM=4, ctrl_en_i=1, writer acks immediately, wr_done_i 10 cycles after ack, ready=1 always:
  - wr_req_o on bank 0, fetch_start_o 2 cycles after done with rd_bank_o=0.
  - A second wr_req_o on bank 1 while bank 0 drains.
  - Bank 0 returns to EMPTY after 4 handshakes.
- Consumer holds ready=0: both banks reach FULL, wr_req_o stays low, bank_full_o=2'b11. With PERF_EN, stall_cnt_o increments each cycle.
- wr_done_i on bank 1 in the same cycle as the 4th handshake on bank 0: bank1 FULL and bank0 EMPTY both apply; next fetch_start_o has rd_bank_o=1.
- ctrl_en_i dropped while in W_REQ with ack delayed 5 cycles: wr_req_o held until ack; the frame completes and drains; busy_o=0 afterwards; no further requests.
- Spurious wr_done_i in W_IDLE: err_o=1 and stays 1; bank states unchanged.
- rst_n asserted during R_DRAIN after 2 handshakes: all outputs 0 asynchronously; after release the first request targets bank 0.
